// File: rtl/demux_rr_dispatcher_if.sv
// Source/sink handshake bundle for the 1-to-4 round-robin demux dispatcher.
// master = dispatcher side, slave = source/sink environment side.
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [1:0]        sel;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ready;
  logic              busy;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, sel, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, sel, out_valid, out_data, busy
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// Round-robin 1-to-4 demux sequencer with per-channel stall timeout.
// Optional skip counter port enabled by defining DEMUX_SKIP_CNT_EN.
//
//   state | meaning
//   IDLE  | ready for a source word, no channel valid
//   HOLD  | word held, one-hot valid on channel sel until delivered
module demux_rr_dispatcher #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_rr_dispatcher_if.master  bus
`ifdef DEMUX_SKIP_CNT_EN
  ,
  output logic [7:0]             skip_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT);
  localparam bit         TO_EN  = (TIMEOUT != 0);

  state_t            state, state_nxt;
  logic [1:0]        ptr;
  logic [1:0]        sel_q;
  logic [7:0]        wait_cnt;
  logic [DATA_W-1:0] data_q;
  logic              accept, deliver, skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    deliver   = 1'b0;
    skip      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // delivery wins over a timeout landing on the same cycle
        if (bus.out_ready[sel_q]) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end else if (TO_EN && (wait_cnt == TO_VAL)) begin
          skip = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 2'd0;
      sel_q    <= 2'd0;
      wait_cnt <= 8'd0;
      data_q   <= '0;
    end else begin
      if (accept) begin
        data_q   <= bus.in_data;
        sel_q    <= ptr;
        wait_cnt <= 8'd0;
      end
      if (deliver) ptr <= 2'(sel_q + 2'd1);
      if (skip) begin
        sel_q    <= 2'(sel_q + 2'd1);
        wait_cnt <= 8'd0;
      end else if (TO_EN && (state == HOLD) && !deliver) begin
        wait_cnt <= 8'(wait_cnt + 8'd1);
      end
    end
  end

`ifdef DEMUX_SKIP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        skip_cnt <= 8'd0;
    else if (skip && skip_cnt != 8'hFF) skip_cnt <= 8'(skip_cnt + 8'd1);
  end
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == HOLD);
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state == HOLD) ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
- Sequencer for the 1-to-4 demultiplexer datapath: accepts one word from a single valid/ready source and delivers it to exactly one of four sink channels.
- Channels are served in round-robin order, starting at channel 0.
- Drives the 2-bit demux select and the one-hot channel valids.
- Skips a sink that stalls longer than a programmable timeout, so one dead sink cannot block the stream.

Parameters:
- DATA_W, 8, width of the data word.
- TIMEOUT, 15, cycles to wait for out_ready before retargeting to the next channel; 0 disables the timeout (wait forever); legal range 0..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source word valid.
- in_data  in  DATA_W  source word.
- in_ready  out  1  dispatcher can accept a word.
- sel  out  2  demux select; sel[1] maps to S1, sel[0] maps to S0.
- out_valid  out  4  one-hot channel valid; bit k is for channel k.
- out_data  out  DATA_W  held word, shared by all channels.
- out_ready  in  4  per-channel sink ready.
- busy  out  1  high while a word is held.

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - state=IDLE, ptr=0, sel=0, out_valid=0, out_data=0, in_ready=1, busy=0, wait counter=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid && in_ready at an edge: latch in_data into out_data, set sel=ptr, clear the counter, go to HOLD.
- State HOLD:
  - in_ready=0, busy=1.
  - out_valid = one-hot(sel); exactly one bit is set, never more.
  - out_data is stable for the whole of HOLD.
- Delivery:
  - Transfer occurs when out_valid[sel] && out_ready[sel] at an edge.
  - On transfer: ptr=sel+1 mod 4 (3 wraps to 0), go to IDLE, out_valid=0 next cycle.
- Timeout (only when TIMEOUT>0):
  - The counter increments each HOLD cycle without a transfer.
  - When the counter reaches TIMEOUT and there is no transfer that cycle: sel=sel+1 mod 4, counter=0, remain in HOLD with the same out_data.
  - The new channel's out_valid rises on the next cycle.
  - A word may circle through all four channels indefinitely; it is never dropped.
- Simultaneous events: a transfer on the cycle the counter reaches TIMEOUT counts as delivery; no skip occurs.
- out_ready on non-selected channels is ignored.
- Latency: input handshake at edge N gives out_valid high from cycle N+1. Peak throughput is 1 word per 2 cycles; no back-to-back acceptance while holding.
- Reset mid-HOLD: the held word is discarded and all state returns to reset values.
- in_data is sampled only on the acceptance edge.

Optional Feature:
- Macro: DEMUX_SKIP_CNT_EN.
- Defined:
  - Adds output port skip_cnt (out, 8): a count of timeout retargets.
  - Saturates at 255; reset to 0 by rst_n.
  - Increments by 1 per skip.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then four words 0x11, 0x22, 0x33, 0x44, all out_ready=4'b1111 → delivered on channels 0, 1, 2, 3 in order, sel=0,1,2,3, then ptr wraps and a fifth word 0x55 goes to channel 0.
2. Accept 0xA5 with out_ready=0 and TIMEOUT=15 → out_valid=4'b0001 for 16 cycles, then 4'b0010. Assert out_ready[1] → delivered on channel 1, next word targets channel 2; skip_cnt=1 when enabled.
3. On the exact cycle the counter reaches TIMEOUT, assert out_ready[sel] → word delivered on that channel, no skip, skip_cnt unchanged.
4. TIMEOUT=0, out_ready=0 for 1000 cycles → out_valid stays 4'b0001, in_ready=0, out_data unchanged.
5. Assert rst_n low mid-HOLD with word 0x3C on channel 2 → immediately out_valid=0, busy=0, in_ready=1. Next word goes to channel 0.
6. out_ready=4'b1110 while sel=0 → no transfer; out_valid stays one-hot 4'b0001 until timeout.
